// File: rtl/midi_poly_voice_allocator_if.sv
// Bundle carrying the UART byte strobe into the allocator and the per-voice
// state plus event pulses out to the voice bank.
interface midi_poly_voice_allocator_if #(
  parameter int NUM_VOICES = 4
);
  logic                    rx_dv;
  logic [7:0]              rx_byte;
  logic [NUM_VOICES-1:0]   voice_gate;
  logic [7*NUM_VOICES-1:0] voice_note;
  logic [7*NUM_VOICES-1:0] voice_vel;
  logic                    evt_valid;
  logic                    evt_on;
  logic [2:0]              evt_voice;
  logic                    evt_all_off;

  modport master (
    output rx_dv, rx_byte,
    input  voice_gate, voice_note, voice_vel,
    input  evt_valid, evt_on, evt_voice, evt_all_off
  );

  modport slave (
    input  rx_dv, rx_byte,
    output voice_gate, voice_note, voice_vel,
    output evt_valid, evt_on, evt_voice, evt_all_off
  );
endinterface

// File: rtl/midi_poly_voice_allocator.sv
// MIDI front end: running-status byte parser, channel filter and a
// polyphonic voice allocator with retrigger, lowest-free and round-robin steal.
// A message is registered on the edge that samples its last data byte and
// applied to the voice slots on the following edge.
module midi_poly_voice_allocator #(
  parameter int NUM_VOICES = 4,
  parameter int CHANNEL    = 0,
  parameter int OMNI       = 0
) (
  input logic clk,
  input logic rst,
  midi_poly_voice_allocator_if.slave bus
);

  localparam int IDX_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;

  typedef enum logic [1:0] {IDLE, WAIT_D1, WAIT_D2} parse_state_t;

  parse_state_t state_q, state_d;
  logic [7:0]   status_q, status_d;
  logic [6:0]   d1_q, d1_d;
  logic         msg_valid_q, msg_valid_d;
  logic [3:0]   msg_type_q, msg_type_d;
  logic [6:0]   msg_d1_q, msg_d1_d;
  logic [6:0]   msg_d2_q, msg_d2_d;
  logic         chan_ok;

  logic [NUM_VOICES-1:0] gate_q, gate_d;
  logic [6:0]            note_q [NUM_VOICES];
  logic [6:0]            note_d [NUM_VOICES];
  logic [6:0]            vel_q  [NUM_VOICES];
  logic [6:0]            vel_d  [NUM_VOICES];
  logic [IDX_W-1:0]      steal_q, steal_d;

  logic       evt_valid_q, evt_valid_d;
  logic       evt_on_q, evt_on_d;
  logic [2:0] evt_voice_q, evt_voice_d;
  logic       evt_all_off_q, evt_all_off_d;

  logic             match_found, free_found;
  logic [IDX_W-1:0] match_idx, free_idx, tgt;

  assign chan_ok = (OMNI != 0) || (status_q[3:0] == 4'(CHANNEL));

  // Parser: tracks running status and collects data bytes into complete messages
  always_comb begin
    state_d     = state_q;
    status_d    = status_q;
    d1_d        = d1_q;
    msg_valid_d = 1'b0;
    msg_type_d  = msg_type_q;
    msg_d1_d    = msg_d1_q;
    msg_d2_d    = msg_d2_q;
    if (bus.rx_dv && (bus.rx_byte < 8'hF8)) begin
      if (bus.rx_byte >= 8'hF0) begin
        state_d  = IDLE;
        status_d = 8'h00;
      end else if (bus.rx_byte[7]) begin
        status_d = bus.rx_byte;
        state_d  = WAIT_D1;
      end else begin
        case (state_q)
          WAIT_D1: begin
            d1_d = bus.rx_byte[6:0];
            if ((status_q[7:4] == 4'hC) || (status_q[7:4] == 4'hD)) begin
              msg_valid_d = chan_ok;
              msg_type_d  = status_q[7:4];
              msg_d1_d    = bus.rx_byte[6:0];
              msg_d2_d    = 7'd0;
            end else begin
              state_d = WAIT_D2;
            end
          end
          WAIT_D2: begin
            msg_valid_d = chan_ok;
            msg_type_d  = status_q[7:4];
            msg_d1_d    = d1_q;
            msg_d2_d    = bus.rx_byte[6:0];
            state_d     = WAIT_D1;
          end
          default: begin
            state_d = IDLE;
          end
        endcase
      end
    end
  end

  // Parser and message registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      status_q    <= 8'h00;
      d1_q        <= 7'd0;
      msg_valid_q <= 1'b0;
      msg_type_q  <= 4'h0;
      msg_d1_q    <= 7'd0;
      msg_d2_q    <= 7'd0;
    end else begin
      state_q     <= state_d;
      status_q    <= status_d;
      d1_q        <= d1_d;
      msg_valid_q <= msg_valid_d;
      msg_type_q  <= msg_type_d;
      msg_d1_q    <= msg_d1_d;
      msg_d2_q    <= msg_d2_d;
    end
  end

  // Find the lowest gated voice holding the message note and the lowest idle voice
  always_comb begin
    match_found = 1'b0;
    match_idx   = '0;
    free_found  = 1'b0;
    free_idx    = '0;
    for (int v = NUM_VOICES - 1; v >= 0; v--) begin
      if (gate_q[v] && (note_q[v] == msg_d1_q)) begin
        match_found = 1'b1;
        match_idx   = IDX_W'(v);
      end
      if (!gate_q[v]) begin
        free_found = 1'b1;
        free_idx   = IDX_W'(v);
      end
    end
  end

  // Allocator: apply a registered message to the voice slots and raise one event
  always_comb begin
    gate_d        = gate_q;
    note_d        = note_q;
    vel_d         = vel_q;
    steal_d       = steal_q;
    evt_valid_d   = 1'b0;
    evt_on_d      = 1'b0;
    evt_voice_d   = 3'd0;
    evt_all_off_d = 1'b0;
    tgt           = steal_q;
    if (msg_valid_q) begin
      if ((msg_type_q == 4'h9) && (msg_d2_q != 7'd0)) begin
        if (match_found) begin
          tgt = match_idx;
        end else if (free_found) begin
          tgt = free_idx;
        end else begin
          tgt     = steal_q;
          steal_d = (steal_q == IDX_W'(NUM_VOICES - 1)) ? '0 : steal_q + 1'b1;
        end
        gate_d[tgt] = 1'b1;
        note_d[tgt] = msg_d1_q;
        vel_d[tgt]  = msg_d2_q;
        evt_valid_d = 1'b1;
        evt_on_d    = 1'b1;
        evt_voice_d = 3'(tgt);
      end else if ((msg_type_q == 4'h8) || (msg_type_q == 4'h9)) begin
        if (match_found) begin
          tgt         = match_idx;
          gate_d[tgt] = 1'b0;
          evt_valid_d = 1'b1;
          evt_voice_d = 3'(tgt);
        end
      end else if ((msg_type_q == 4'hB) && (msg_d1_q == 7'd123)) begin
        gate_d        = '0;
        evt_valid_d   = 1'b1;
        evt_all_off_d = 1'b1;
      end
    end
  end

  // Voice slot, steal pointer and event registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gate_q        <= '0;
      note_q        <= '{default: '0};
      vel_q         <= '{default: '0};
      steal_q       <= '0;
      evt_valid_q   <= 1'b0;
      evt_on_q      <= 1'b0;
      evt_voice_q   <= 3'd0;
      evt_all_off_q <= 1'b0;
    end else begin
      gate_q        <= gate_d;
      note_q        <= note_d;
      vel_q         <= vel_d;
      steal_q       <= steal_d;
      evt_valid_q   <= evt_valid_d;
      evt_on_q      <= evt_on_d;
      evt_voice_q   <= evt_voice_d;
      evt_all_off_q <= evt_all_off_d;
    end
  end

  for (genvar g = 0; g < NUM_VOICES; g++) begin : g_pack
    assign bus.voice_note[7*g +: 7] = note_q[g];
    assign bus.voice_vel[7*g +: 7]  = vel_q[g];
  end

  assign bus.voice_gate  = gate_q;
  assign bus.evt_valid   = evt_valid_q;
  assign bus.evt_on      = evt_on_q;
  assign bus.evt_voice   = evt_voice_q;
  assign bus.evt_all_off = evt_all_off_q;

endmodule

// File: tb/tb_midi_poly_voice_allocator.sv
// Bench for midi_poly_voice_allocator: directed byte sequences followed by
// random traffic, each cycle compared against a message-level voice model.
module tb_midi_poly_voice_allocator;

  localparam int NV   = 4;
  localparam int CHAN = 2;

  typedef struct {
    logic [NV-1:0]   gate;
    logic [7*NV-1:0] note;
    logic [7*NV-1:0] vel;
    logic            ev;
    logic            on;
    logic [2:0]      voice;
    logic            all_off;
  } snap_t;

  logic clk;
  logic rst;

  midi_poly_voice_allocator_if #(.NUM_VOICES(NV)) bus ();

  midi_poly_voice_allocator #(
    .NUM_VOICES(NV),
    .CHANNEL   (CHAN),
    .OMNI      (0)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int compared   = 0;
  int mismatched = 0;

  int m_rs;
  int m_data[$];
  bit m_gate[NV];
  int m_note[NV];
  int m_vel[NV];
  int m_steal;

  snap_t exp_q[$];

  // Free-running clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    if (obs !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic snap_t makeSnap(bit ev, bit on, int vc, bit ao);
    snap_t s;
    for (int v = 0; v < NV; v++) begin
      s.gate[v]       = m_gate[v];
      s.note[7*v +: 7] = 7'(m_note[v]);
      s.vel[7*v +: 7]  = 7'(m_vel[v]);
    end
    s.ev      = ev;
    s.on      = on;
    s.voice   = 3'(vc);
    s.all_off = ao;
    return s;
  endfunction

  task automatic modelReset();
    m_rs = -1;
    m_data.delete();
    for (int v = 0; v < NV; v++) begin
      m_gate[v] = 1'b0;
      m_note[v] = 0;
      m_vel[v]  = 0;
    end
    m_steal = 0;
    exp_q.delete();
    exp_q.push_back(makeSnap(0, 0, 0, 0));
    exp_q.push_back(makeSnap(0, 0, 0, 0));
  endtask

  // Reference model: consume one byte, apply any completed message to the voices
  task automatic modelByte(input int b, output snap_t s);
    bit ev = 0;
    bit on = 0;
    bit ao = 0;
    int vc = 0;
    int need, d1, d2, typ, idx;
    if (b < 'hF8) begin
      if (b >= 'hF0) begin
        m_rs = -1;
        m_data.delete();
      end else if (b >= 'h80) begin
        m_rs = b;
        m_data.delete();
      end else if (m_rs >= 0) begin
        m_data.push_back(b);
        typ  = m_rs >> 4;
        need = (typ == 12 || typ == 13) ? 1 : 2;
        if (m_data.size() == need) begin
          d1 = m_data[0];
          d2 = (need == 2) ? m_data[1] : 0;
          m_data.delete();
          if ((m_rs & 15) == CHAN) begin
            idx = -1;
            for (int v = 0; v < NV; v++)
              if (idx < 0 && m_gate[v] && m_note[v] == d1) idx = v;
            if (typ == 9 && d2 > 0) begin
              for (int v = 0; v < NV; v++)
                if (idx < 0 && !m_gate[v]) idx = v;
              if (idx < 0) begin
                idx     = m_steal;
                m_steal = (m_steal + 1) % NV;
              end
              m_gate[idx] = 1'b1;
              m_note[idx] = d1;
              m_vel[idx]  = d2;
              ev = 1; on = 1; vc = idx;
            end else if (typ == 8 || typ == 9) begin
              if (idx >= 0) begin
                m_gate[idx] = 1'b0;
                ev = 1; vc = idx;
              end
            end else if (typ == 11 && d1 == 123) begin
              for (int v = 0; v < NV; v++) m_gate[v] = 1'b0;
              ev = 1; ao = 1;
            end
          end
        end
      end
    end
    s = makeSnap(ev, on, vc, ao);
  endtask

  // One cycle: check outputs due now, then present the next byte
  task automatic applyStimulus(input bit dv, input int b);
    snap_t s;
    @(negedge clk);
    if (exp_q.size() >= 2) begin
      s = exp_q.pop_front();
      checkOutput("voice_gate",  64'(bus.voice_gate),  64'(s.gate));
      checkOutput("voice_note",  64'(bus.voice_note),  64'(s.note));
      checkOutput("voice_vel",   64'(bus.voice_vel),   64'(s.vel));
      checkOutput("evt_valid",   64'(bus.evt_valid),   64'(s.ev));
      checkOutput("evt_on",      64'(bus.evt_on),      64'(s.on));
      checkOutput("evt_voice",   64'(bus.evt_voice),   64'(s.voice));
      checkOutput("evt_all_off", 64'(bus.evt_all_off), 64'(s.all_off));
    end
    bus.rx_dv   = dv;
    bus.rx_byte = 8'(b);
    if (dv) modelByte(b, s);
    else    s = makeSnap(0, 0, 0, 0);
    exp_q.push_back(s);
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_gate"},    64'(bus.voice_gate),  64'd0);
    checkOutput({tag, "_note"},    64'(bus.voice_note),  64'd0);
    checkOutput({tag, "_vel"},     64'(bus.voice_vel),   64'd0);
    checkOutput({tag, "_valid"},   64'(bus.evt_valid),   64'd0);
    checkOutput({tag, "_on"},      64'(bus.evt_on),      64'd0);
    checkOutput({tag, "_voice"},   64'(bus.evt_voice),   64'd0);
    checkOutput({tag, "_all_off"}, 64'(bus.evt_all_off), 64'd0);
  endtask

  // Assert reset between edges, confirm it acts without a clock, release it
  task automatic resetDut();
    #2;
    rst       = 1'b1;
    bus.rx_dv = 1'b0;
    #1;
    checkResetState("async_rst");
    @(negedge clk);
    rst = 1'b0;
    modelReset();
  endtask

  task automatic sendBytes(input int bytes[$]);
    foreach (bytes[i]) applyStimulus(1'b1, bytes[i]);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 0);
  endtask

  function automatic int randByte();
    int r;
    int t;
    r = $urandom_range(0, 99);
    if (r < 4) return 'hF8 + $urandom_range(0, 7);
    if (r < 7) return 'hF0 + $urandom_range(0, 7);
    if (r < 27) begin
      case ($urandom_range(0, 8))
        0:       t = 8;
        1, 2, 3: t = 9;
        4:       t = 11;
        5:       t = 12;
        6:       t = 13;
        7:       t = 14;
        default: t = 10;
      endcase
      return (t << 4) | (($urandom_range(0, 9) < 7) ? CHAN : $urandom_range(0, 15));
    end
    if (r < 70) return 'h3C + $urandom_range(0, 7);
    if (r < 80) return 0;
    if (r < 85) return 123;
    return $urandom_range(0, 127);
  endfunction

  // Main sequence: directed scenarios then random traffic
  initial begin
    rst         = 1'b1;
    bus.rx_dv   = 1'b0;
    bus.rx_byte = 8'h00;
    #3;
    checkResetState("por");
    @(negedge clk);
    rst = 1'b0;
    modelReset();

    sendBytes('{'h92, 'h3C, 'h64});
    idle(3);

    resetDut();
    sendBytes('{'h92, 'h3C, 'h64, 'h40, 'h50, 'h3C, 'h00});
    idle(3);

    resetDut();
    sendBytes('{'h92, 'h40, 'h7F, 'h41, 'h7F, 'h42, 'h7F, 'h43, 'h7F,
                'h44, 'h7F, 'h45, 'h7F, 'h46, 'h7F, 'h47, 'h7F, 'h48, 'h7F});
    idle(3);

    resetDut();
    sendBytes('{'h92, 'h3C, 'hF8, 'h64});
    sendBytes('{'h92, 'h3C, 'h82, 'h3E, 'h00});
    idle(3);

    sendBytes('{'h91, 'h3C, 'h64, 'h92, 'h3C, 'h64, 'hB2, 'h7B, 'h00});
    idle(3);

    sendBytes('{'h92, 'h3C});
    resetDut();
    sendBytes('{'h64});
    idle(3);

    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 99) < 85) applyStimulus(1'b1, randByte());
      else                            applyStimulus(1'b0, $urandom_range(0, 255));
    end
    idle(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
